// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Holds operands for EXEC_CYCLES, captures the result and owns the N/Z/V flags.
module alu_share_arbiter #(
  parameter int DATA_W      = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_n,
  input  logic              alu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t state;
  state_t state_d;

  logic [3:0]        cnt;
  logic              last_grant;
  logic              grant_id;
  logic              grant_vld;
  logic              accept;
  logic              cnt_done;

  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              id_q;

  logic              wr_nv;
  logic              wr_z;
  logic              res_zero;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant_id  = 1'b0;
    grant_vld = 1'b0;
    unique case (1'b1)
      (req0_valid && req1_valid): begin
        grant_id  = ~last_grant;
        grant_vld = 1'b1;
      end
      (req0_valid && !req1_valid): begin
        grant_id  = 1'b0;
        grant_vld = 1'b1;
      end
      (!req0_valid && req1_valid): begin
        grant_id  = 1'b1;
        grant_vld = 1'b1;
      end
      default: begin
        grant_id  = 1'b0;
        grant_vld = 1'b0;
      end
    endcase
  end

  assign accept   = (state == IDLE) && grant_vld;
  assign cnt_done = (cnt == 4'd0);
  assign res_zero = (alu_result == '0);

  always_comb begin
    wr_nv = 1'b0;
    wr_z  = 1'b0;
    case (op_q)
      4'b0000,
      4'b0001: begin
        wr_nv = 1'b1;
        wr_z  = 1'b1;
      end
      4'b0010,
      4'b0100,
      4'b0101,
      4'b0110: begin
        wr_z  = 1'b1;
      end
      default: begin
        wr_nv = 1'b0;
        wr_z  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_done) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (accept) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
    busy = (state != IDLE);
  end

  // Operands stay registered in every state so the ALU never sees X.
  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q       <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
    end else if (accept) begin
      op_q       <= grant_id ? req1_op : req0_op;
      a_q        <= grant_id ? req1_a : req0_a;
      b_q        <= grant_id ? req1_b : req0_b;
      id_q       <= grant_id;
      last_grant <= grant_id;
      cnt        <= CNT_INIT;
    end else if (state == EXEC && !cnt_done) begin
      cnt        <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else if (state == EXEC && cnt_done) begin
      rsp_valid <= 1'b1;
      rsp_id    <= id_q;
      rsp_data  <= alu_result;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Masked-off flags keep their previous value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else if (state == EXEC && cnt_done) begin
      if (wr_nv) begin
        flag_n <= alu_n;
        flag_v <= alu_v;
      end
      if (wr_z) begin
        flag_z <= res_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: scoreboarded directed steps on two instances
// (EXEC_CYCLES=1 and EXEC_CYCLES=3) driven by a behavioural ALU.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  typedef struct packed {
    logic        id;
    logic [15:0] d;
    logic        n;
    logic        z;
    logic        v;
  } exp_t;

  exp_t q[$];
  logic m_n, m_z, m_v;

  function automatic logic [17:0] alu_f(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    logic v;
    r = a + b;
    v = 1'b0;
    case (op)
      4'h0: begin
        r = a + b;
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h1: begin
        r = a - b;
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'h2: r = a ^ b;
      4'h4: r = a << b[3:0];
      4'h5: r = $signed(a) >>> b[3:0];
      4'h6: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
      4'hA: r = {a[15:8], b[7:0]};
      default: r = a + b;
    endcase
    return {r[15], v, r};
  endfunction

  // DUT with EXEC_CYCLES=1
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [15:0] alu_result, rsp_data;
  logic        alu_n, alu_v, rsp_valid, rsp_ready, rsp_id;
  logic        flag_n, flag_z, flag_v, busy;

  assign {alu_n, alu_v, alu_result} = alu_f(alu_op, alu_a, alu_b);

  alu_share_arbiter #(.DATA_W(16), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .busy(busy)
  );

  // DUT with EXEC_CYCLES=3
  logic        x_rst;
  logic        x_req0_valid, x_req0_ready, x_req1_valid, x_req1_ready;
  logic [3:0]  x_req0_op, x_req1_op, x_alu_op;
  logic [15:0] x_req0_a, x_req0_b, x_req1_a, x_req1_b, x_alu_a, x_alu_b;
  logic [15:0] x_alu_result, x_rsp_data;
  logic        x_alu_n, x_alu_v, x_rsp_valid, x_rsp_ready, x_rsp_id;
  logic        x_flag_n, x_flag_z, x_flag_v, x_busy;

  assign {x_alu_n, x_alu_v, x_alu_result} = alu_f(x_alu_op, x_alu_a, x_alu_b);

  alu_share_arbiter #(.DATA_W(16), .EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst(x_rst),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready),
    .req0_op(x_req0_op), .req0_a(x_req0_a), .req0_b(x_req0_b),
    .req1_valid(x_req1_valid), .req1_ready(x_req1_ready),
    .req1_op(x_req1_op), .req1_a(x_req1_a), .req1_b(x_req1_b),
    .alu_op(x_alu_op), .alu_a(x_alu_a), .alu_b(x_alu_b),
    .alu_result(x_alu_result), .alu_n(x_alu_n), .alu_v(x_alu_v),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready),
    .rsp_id(x_rsp_id), .rsp_data(x_rsp_data),
    .flag_n(x_flag_n), .flag_z(x_flag_z), .flag_v(x_flag_v),
    .busy(x_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b);
    logic [17:0] f;
    exp_t e;
    f = alu_f(op, a, b);
    if (op == 4'h0 || op == 4'h1) begin
      m_n = f[17];
      m_v = f[16];
    end
    if (op == 4'h0 || op == 4'h1 || op == 4'h2 ||
        op == 4'h4 || op == 4'h5 || op == 4'h6) begin
      m_z = (f[15:0] == 16'h0);
    end
    e.id = id;
    e.d  = f[15:0];
    e.n  = m_n;
    e.z  = m_z;
    e.v  = m_v;
    q.push_back(e);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      ntests++;
      nfail++;
      $error("FAIL %s: scoreboard empty on response", tag);
    end else begin
      e = q.pop_front();
      chk(tag, {rsp_valid, rsp_id, rsp_data, flag_n, flag_z, flag_v},
          {1'b1, e.id, e.d, e.n, e.z, e.v});
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    m_n = 1'b0;
    m_z = 1'b0;
    m_v = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One operation from an idle DUT, checking one-cycle latency and handshake.
  task automatic do_op(input string tag, input logic id, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    int lat;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    chk({tag, "_ready"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
    push_exp(id, op, a, b);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, 1);
    check_rsp(tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {rsp_valid, busy}, 2'b00);
  endtask

  int i0, i1, guard, lat;
  logic exp_last, exp_g;
  logic [15:0] hold_d;
  logic hold_id;

  task automatic set_reqs();
    req0_valid = (i0 < 4);
    req0_op = 4'h0;
    req0_a = 16'(i0 * 16'h1111);
    req0_b = 16'h0101;
    req1_valid = (i1 < 4);
    req1_op = 4'h1;
    req1_a = 16'(i1 * 16'h0100);
    req1_b = 16'h0003;
  endtask

  initial begin
    req0_op = 0; req0_a = 0; req0_b = 0;
    req1_op = 0; req1_a = 0; req1_b = 0;
    x_rst = 1'b0; x_rsp_ready = 1'b0;
    x_req0_valid = 0; x_req0_op = 0; x_req0_a = 0; x_req0_b = 0;
    x_req1_valid = 0; x_req1_op = 0; x_req1_a = 0; x_req1_b = 0;

    // Reset state and first ADD with overflow
    do_reset();
    chk("rst_state", {busy, rsp_valid, rsp_id, rsp_data, flag_n, flag_z, flag_v},
        21'h0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 36'h0);
    do_op("add_ovf", 1'b0, 4'h0, 16'h7FFF, 16'h0001);
    chk("add_ovf_val", {rsp_data, flag_n, flag_z, flag_v}, {16'h8000, 3'b101});

    // Both requesters always valid: grants alternate starting with req0
    do_reset();
    rsp_ready = 1'b1;
    i0 = 0; i1 = 0; guard = 0; exp_last = 1'b1;
    while ((i0 < 4 || i1 < 4) && guard < 40) begin
      guard++;
      set_reqs();
      #1;
      exp_g = (i0 < 4 && i1 < 4) ? ~exp_last : (i0 < 4 ? 1'b0 : 1'b1);
      chk("rr_grant", {req1_ready, req0_ready}, exp_g ? 2'b10 : 2'b01);
      if (exp_g) push_exp(1'b1, req1_op, req1_a, req1_b);
      else push_exp(1'b0, req0_op, req0_a, req0_b);
      exp_last = exp_g;
      step();
      if (exp_g) i1++;
      else i0++;
      set_reqs();
      #1;
      chk("rr_exec_hold", {req1_ready, req0_ready}, 2'b00);
      wait_rsp(lat);
      chk("rr_lat", lat, 1);
      check_rsp("rr_rsp");
      step();
    end
    chk("rr_count", {i0[7:0], i1[7:0]}, 16'h0404);
    chk("rr_sb_empty", q.size(), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    step();

    // Flag masking: XOR writes only Z, LLB writes nothing
    do_reset();
    do_op("f_add", 1'b0, 4'h0, 16'h7FFF, 16'h0001);
    do_op("f_xor", 1'b0, 4'h2, 16'h1234, 16'h1234);
    chk("f_xor_val", {rsp_data, flag_n, flag_z, flag_v}, {16'h0000, 3'b111});
    do_op("f_llb", 1'b1, 4'hA, 16'h0000, 16'h0012);
    chk("f_llb_val", {rsp_data, flag_n, flag_z, flag_v}, {16'h0012, 3'b111});

    // Response back-pressure for 5 cycles with both requesters waiting
    req0_valid = 1'b1; req0_op = 4'h4; req0_a = 16'h0003; req0_b = 16'h0002;
    #1;
    push_exp(1'b0, 4'h4, 16'h0003, 16'h0002);
    step();
    wait_rsp(lat);
    chk("bp_lat", lat, 1);
    check_rsp("bp_rsp");
    hold_d = rsp_data;
    hold_id = rsp_id;
    req1_valid = 1'b1; req1_op = 4'h6; req1_a = 16'h8001; req1_b = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, hold_id, hold_d});
      chk("bp_ready0", {req1_ready, req0_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_release", {rsp_valid, busy}, 2'b00);
    chk("bp_next_grant", {req1_ready, req0_ready}, 2'b10);
    push_exp(1'b1, 4'h6, 16'h8001, 16'h0001);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("bp_accepted", busy, 1'b1);
    wait_rsp(lat);
    chk("bp2_lat", lat, 1);
    check_rsp("bp2_rsp");
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // EXEC_CYCLES=3: SUB 5-5 holds operands 3 cycles
    step();
    x_rst = 1'b1;
    x_req0_valid = 1'b1; x_req0_op = 4'h1; x_req0_a = 16'h0005; x_req0_b = 16'h0005;
    #1;
    chk("x_ready", {x_req1_ready, x_req0_ready}, 2'b01);
    step();
    x_req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("x_alu_stable", {x_alu_op, x_alu_a, x_alu_b}, {4'h1, 16'h0005, 16'h0005});
      chk("x_no_rsp", {x_rsp_valid, x_req1_ready, x_req0_ready}, 3'b000);
      step();
    end
    chk("x_rsp", {x_rsp_valid, x_rsp_id, x_rsp_data, x_flag_n, x_flag_z, x_flag_v},
        {1'b1, 1'b0, 16'h0000, 3'b010});
    x_rsp_ready = 1'b1;
    step();
    x_rsp_ready = 1'b0;

    // Reset during EXEC discards the op and clears flags
    x_req1_valid = 1'b1; x_req1_op = 4'h0; x_req1_a = 16'hFFFF; x_req1_b = 16'hFFFF;
    step();
    x_req1_valid = 1'b0;
    chk("x6_exec", x_busy, 1'b1);
    x_rst = 1'b0;
    step();
    chk("x6_rst", {x_busy, x_rsp_valid, x_rsp_data, x_flag_n, x_flag_z, x_flag_v},
        21'h0);
    chk("x6_rst_alu", {x_alu_op, x_alu_a, x_alu_b}, 36'h0);
    x_rst = 1'b1;
    x_req0_valid = 1'b1; x_req0_op = 4'h0; x_req0_a = 16'h0002; x_req0_b = 16'h0003;
    x_req1_valid = 1'b1;
    #1;
    chk("x6_first_grant", {x_req1_ready, x_req0_ready}, 2'b01);
    step();
    x_req0_valid = 1'b0;
    x_req1_valid = 1'b0;
    guard = 0;
    while (!x_rsp_valid && guard < 20) begin
      step();
      guard++;
    end
    chk("x6_lat", guard, 3);
    chk("x6_rsp", {x_rsp_valid, x_rsp_id, x_rsp_data, x_flag_n, x_flag_z, x_flag_v},
        {1'b1, 1'b0, 16'h0005, 3'b000});
    x_rsp_ready = 1'b1;
    step();
    x_rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
